// File: rtl/router_pkg.sv
// Shared constants, FSM encoding and small helpers for the hypercube router
// receive path. The optional frame parity bit is enabled by defining
// DIM_RX_PARITY_EN, which lengthens the frame by one bit.
package router_pkg;

    localparam int ADDR_W    = 12;
    localparam int DIM_W     = 4;
    localparam int PRI_W     = 3;
    localparam int DATA_W    = 32;
    localparam int NBUF      = 7;
    localparam int BUF_W     = 3;

    // Buffer number 0 is the dummy/empty slot.
    localparam logic [BUF_W-1:0] BUF_NONE = 3'd0;

    // Bits carried after the start bit, excluding any parity bit.
    localparam int PAYLOAD_W = ADDR_W + PRI_W + DATA_W;

`ifdef DIM_RX_PARITY_EN
    localparam int FRAME_LEN = PAYLOAD_W + 1;
`else
    localparam int FRAME_LEN = PAYLOAD_W;
`endif

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DATA   = 3'd2,
        ST_PAR    = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DRAIN  = 3'd5
    } rx_state_t;

    // One hop ages the priority by one, saturating at all-ones.
    function automatic logic [PRI_W-1:0] age_pri(input logic [PRI_W-1:0] pri);
        logic [PRI_W-1:0] aged;
        if (pri == {PRI_W{1'b1}}) begin
            aged = pri;
        end else begin
            aged = pri + PRI_W'(1);
        end
        return aged;
    endfunction

    // Even parity over the payload: the parity bit equals the XOR of all bits.
    function automatic logic even_parity(input logic [PAYLOAD_W-1:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/free_buf_pick.sv
// Combinational priority encoder: lowest-numbered free buffer wins.
// Bit i-1 of buf_free corresponds to buffer number i.
module free_buf_pick
    import router_pkg::*;
(
    input  logic [NBUF-1:0]  buf_free,
    output logic             found,
    output logic [BUF_W-1:0] pick
);

    // Scan downwards so the last hit written is the lowest free index.
    always_comb begin
        found = 1'b0;
        pick  = BUF_NONE;
        for (int i = NBUF - 1; i >= 0; i--) begin
            found = found | buf_free[i];
            pick  = buf_free[i] ? BUF_W'(i + 1) : pick;
        end
    end

endmodule

// File: rtl/dim_receiver.sv
// Receive end of one hypercube dimension link. Deserialises one bit-serial
// frame (start, addr LSB first, pri MSB first, data MSB first), reserves the
// lowest free local buffer on the start bit, clears the address bit of the
// dimension just traversed, ages the priority and issues a one-cycle write.
// Define DIM_RX_PARITY_EN to expect a trailing even-parity bit.
module dim_receiver
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIM_W-1:0]  cur_dim,
    input  logic              dim_start,
    input  logic              rx_bit,
    input  logic [NBUF-1:0]   buf_free,
    output logic              rx_ack,
    output logic              rx_nak,
    output logic              rsv_valid,
    output logic [BUF_W-1:0]  rsv_buf,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PRI_W-1:0]  wr_pri,
    output logic [DATA_W-1:0] wr_data,
    output logic              err
);

    // The final frame bit is taken straight from rx_bit, so one bit fewer is stored.
    localparam int SHIFT_W = FRAME_LEN - 1;
    localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(ADDR_W + PRI_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
`ifdef DIM_RX_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_PAYLOAD = CNT_W'(PAYLOAD_W - 1);
`endif

    rx_state_t            state_r;
    rx_state_t            next_body_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [SHIFT_W-1:0]   shift_r;
    logic [DIM_W-1:0]     dim_r;

    logic [PAYLOAD_W-1:0] frame_s;
    logic [ADDR_W-1:0]    addr_s;
    logic [ADDR_W-1:0]    clr_addr_s;
    logic [PRI_W-1:0]     pri_s;
    logic [DATA_W-1:0]    data_s;
    logic                 dim_ok_s;
    logic                 par_ok_s;
    logic                 found_s;
    logic [BUF_W-1:0]     pick_s;

    free_buf_pick u_pick (
        .buf_free (buf_free),
        .found    (found_s),
        .pick     (pick_s)
    );

    // Assemble the complete payload as it stands on the final frame bit and decode its fields.
    always_comb begin
`ifdef DIM_RX_PARITY_EN
        frame_s  = shift_r;
        par_ok_s = (even_parity(shift_r) == rx_bit);
`else
        frame_s  = {shift_r, rx_bit};
        par_ok_s = 1'b1;
`endif
        for (int i = 0; i < ADDR_W; i++) begin
            addr_s[i] = frame_s[PAYLOAD_W - 1 - i];
        end
        pri_s      = frame_s[DATA_W +: PRI_W];
        data_s     = frame_s[DATA_W-1:0];
        dim_ok_s   = 1'b0;
        clr_addr_s = addr_s;
        for (int i = 0; i < ADDR_W; i++) begin
            dim_ok_s      = dim_ok_s | ((dim_r == DIM_W'(i)) & addr_s[i]);
            clr_addr_s[i] = addr_s[i] & (dim_r != DIM_W'(i));
        end
    end

    // Field-to-field transitions inside a frame body, driven by the bit counter.
    always_comb begin
        case (state_r)
            ST_HDR:  next_body_s = (cnt_r == LAST_HDR) ? ST_DATA : ST_HDR;
`ifdef DIM_RX_PARITY_EN
            ST_DATA: next_body_s = (cnt_r == LAST_PAYLOAD) ? ST_PAR : ST_DATA;
`else
            ST_DATA: next_body_s = ST_DATA;
`endif
            default: next_body_s = state_r;
        endcase
    end

    // Receive FSM with registered handshake, reservation and write outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            shift_r   <= {SHIFT_W{1'b0}};
            dim_r     <= {DIM_W{1'b0}};
            rx_ack    <= 1'b0;
            rx_nak    <= 1'b0;
            rsv_valid <= 1'b0;
            rsv_buf   <= BUF_NONE;
            wr_en     <= 1'b0;
            wr_addr   <= {ADDR_W{1'b0}};
            wr_pri    <= {PRI_W{1'b0}};
            wr_data   <= {DATA_W{1'b0}};
            err       <= 1'b0;
        end else begin
            rx_ack <= 1'b0;
            rx_nak <= 1'b0;
            wr_en  <= 1'b0;
            err    <= 1'b0;

            if (dim_start) begin
                dim_r <= cur_dim;
            end

            // The reservation is held through the wr_en/err cycle and released after it;
            // a new reservation made in the same cycle below takes precedence.
            if (wr_en || err) begin
                rsv_valid <= 1'b0;
                rsv_buf   <= BUF_NONE;
            end

            case (state_r)
                ST_IDLE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    shift_r <= {SHIFT_W{1'b0}};
                    if (rx_bit) begin
                        if (found_s) begin
                            state_r   <= ST_HDR;
                            rsv_valid <= 1'b1;
                            rsv_buf   <= pick_s;
                            rx_ack    <= 1'b1;
                        end else begin
                            state_r <= ST_DRAIN;
                            rx_nak  <= 1'b1;
                        end
                    end
                end

                ST_HDR, ST_DATA, ST_PAR: begin
                    if (dim_start) begin
                        state_r <= ST_IDLE;
                        err     <= 1'b1;
                    end else if (cnt_r == LAST_BIT) begin
                        state_r <= ST_COMMIT;
                        if (dim_ok_s && par_ok_s) begin
                            wr_en   <= 1'b1;
                            wr_addr <= clr_addr_s;
                            wr_pri  <= age_pri(pri_s);
                            wr_data <= data_s;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        shift_r <= {shift_r[SHIFT_W-2:0], rx_bit};
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= next_body_s;
                    end
                end

                ST_COMMIT: begin
                    state_r <= ST_IDLE;
                end

                ST_DRAIN: begin
                    if (dim_start) begin
                        state_r <= ST_IDLE;
                        err     <= 1'b1;
                    end else if (cnt_r == LAST_BIT) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
